// File: rtl/mysystem_mem_test_pkg.sv
// Shared types and default widths for the memory test master.
package mysystem_mem_test_pkg;

    localparam int ADDR_W_DFLT = 13;
    localparam int DATA_W_DFLT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RD_WAIT,
        ST_FIN
    } state_e;

endpackage

// File: rtl/mysystem_mem_test_master.sv
// Avalon-MM memory test master: writes seed+i to base+i, then reads back
// and compares one word at a time, reporting mismatch count and first address.
module mysystem_mem_test_master
    import mysystem_mem_test_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic                avm_read,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid
);

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     length_q, length_d;
    logic [ADDR_W:0]     index_q, index_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   ferr_q, ferr_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic                pass_q, pass_d;
    logic                done_q, done_d;

    logic                last;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   pattern;

    always_comb begin
        last     = (index_q == length_q - LEN_ONE);
        addr     = base_q + index_q[ADDR_W-1:0];
        pattern  = seed_q + DATA_W'(index_q);

        state_d  = state_q;
        base_d   = base_q;
        length_d = length_q;
        index_d  = index_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        seed_d   = seed_q;
        pass_d   = pass_q;
        done_d   = 1'b0;

        avm_address    = '0;
        avm_chipselect = 1'b0;
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        avm_byteenable = '0;
        avm_writedata  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base;
                    length_d = length;
                    seed_d   = seed;
                    index_d  = '0;
                    err_d    = '0;
                    ferr_d   = '0;
                    pass_d   = 1'b0;
                    state_d  = (length == '0) ? ST_FIN : ST_WRITE;
                end
            end
            ST_WRITE: begin
                avm_address    = addr;
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_byteenable = '1;
                avm_writedata  = pattern;
                if (!avm_waitrequest) begin
                    if (last) begin
                        index_d = '0;
                        state_d = ST_READ;
                    end else begin
                        index_d = index_q + LEN_ONE;
                    end
                end
            end
            ST_READ: begin
                avm_address    = addr;
                avm_chipselect = 1'b1;
                avm_read       = 1'b1;
                if (!avm_waitrequest) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    if (avm_readdata != pattern) begin
                        if (err_q != '1) begin
                            err_d = err_q + LEN_ONE;
                        end
                        if (err_q == '0) begin
                            ferr_d = addr;
                        end
                    end
                    if (last) begin
                        state_d = ST_FIN;
                    end else begin
                        index_d = index_q + LEN_ONE;
                        state_d = ST_READ;
                    end
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset clears every status flop so no partial result survives an abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            length_q <= '0;
            index_q  <= '0;
            err_q    <= '0;
            ferr_q   <= '0;
            seed_q   <= '0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            length_q <= length_d;
            index_q  <= index_d;
            err_q    <= err_d;
            ferr_q   <= ferr_d;
            seed_q   <= seed_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: doc/mysystem_mem_test_master.md
MYSYSTEM_MEM_TEST_MASTER -- requirements
Module: mysystem_mem_test_master

Interface
REQ-001 Parameter ADDR_W, default 13, SHALL set the word-address width of the Avalon-MM master port.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; byteenable width is DATA_W/8.
REQ-003 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL be a one-cycle pulse that begins a test run.
REQ-006 base  in  ADDR_W  SHALL be the first word address, sampled on start.
REQ-007 length  in  ADDR_W+1  SHALL be the word count, sampled on start.
REQ-008 seed  in  DATA_W  SHALL be the pattern seed, sampled on start.
REQ-009 busy  out  1  SHALL be high from the cycle after start until done.
REQ-010 done  out  1  SHALL be a one-cycle completion pulse.
REQ-011 pass  out  1  SHALL be high when the last run had zero mismatches.
REQ-012 err_count  out  ADDR_W+1  SHALL be the mismatch count of the current or last run.
REQ-013 first_err_addr  out  ADDR_W  SHALL be the address of the first mismatch.
REQ-014 avm_address, avm_chipselect, avm_write, avm_read, avm_byteenable, avm_writedata  out  SHALL form the Avalon-MM command.
REQ-015 avm_readdata  in  DATA_W, avm_waitrequest  in  1, avm_readdatavalid  in  1  SHALL form the Avalon-MM response.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, READ, RD_WAIT, FIN.
REQ-017 IDLE + start: length==0 -> FIN; otherwise -> WRITE, with index=0 and err_count, first_err_addr and pass cleared.
REQ-018 start while busy SHALL be ignored.
REQ-019 In WRITE: avm_write=1, avm_chipselect=1, byteenable all ones, address=(base+index) mod 2^ADDR_W, writedata=(seed+index) mod 2^DATA_W.
REQ-020 The command SHALL be held stable while avm_waitrequest=1; a beat is accepted on a cycle with waitrequest=0.
REQ-021 On the last write acceptance (index==length-1), the FSM SHALL go to READ with index=0; otherwise index increments.
REQ-022 In READ, avm_read=1 and avm_chipselect=1 at the same address; on acceptance the FSM goes to RD_WAIT with all command strobes low.
REQ-023 Exactly one read SHALL be outstanding; in RD_WAIT, avm_readdatavalid compares readdata to seed+index.
REQ-024 Mismatch: err_count increments, saturating at all ones; first_err_addr is captured only when err_count was 0.
REQ-025 After a compare, the FSM SHALL go to FIN when index==length-1, else to READ with index+1.
REQ-026 FIN SHALL assert done for one cycle, set pass=(err_count==0) and return to IDLE.
REQ-027 Latency: avm_write asserts the cycle after start; with a zero-wait slave, one write per cycle; each read costs 1 + slave read latency cycles.
REQ-028 avm_write and avm_read SHALL never be high together.

Reset
REQ-029 While reset_n=0, the block SHALL be in IDLE and every output SHALL be 0, including pass, with no clock needed.
REQ-030 Reset mid-run SHALL abandon the transfer; no partial status is retained.

Structure
REQ-031 Package mysystem_mem_test_pkg SHALL hold the state enum and the ADDR_W/DATA_W defaults.
REQ-032 The block SHALL be a single module with no sub-modules; it SHALL be roughly 150-250 RTL lines.

Verification
REQ-033 Run base=0, length=4, seed=0x10 against a zero-wait memory with read latency 1 -> writes 0x10..0x13 to addresses 0..3, one done pulse, pass=1, err_count=0.
REQ-034 Repeat with waitrequest high for 3 cycles per beat -> command stable while stalled, exactly 4 writes and 4 reads, pass=1.
REQ-035 Slave returns readdata^1 at address 2 -> err_count=1, first_err_addr=2, pass=0.
REQ-036 base=0x1FFE, length=4 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-037 length=0 -> no avm_write or avm_read, done pulse 2 cycles after start, pass=1.
REQ-038 Drop reset_n mid-WRITE -> outputs go to 0 immediately; after release, a new start completes correctly.
